// File: rtl/rv_mul_pkg.sv
// rv_mul_pkg: shared constants, op encodings and FSM states for the RV32M multiply sequencer.
package rv_mul_pkg;
    localparam int XLEN  = 32;
    localparam int CNT_W = 6;
    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'd0,
        MUL_OP_MULH   = 2'd1,
        MUL_OP_MULHSU = 2'd2,
        MUL_OP_MULHU  = 2'd3
    } mul_op_e;
    typedef enum logic [2:0] {
        S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_NEG_LO, S_NEG_HI, S_DONE
    } mul_state_e;
endpackage

// File: rtl/mul_seq_ctrl_hc_add.sv
// mul_seq_ctrl_hc_add: 32-bit Han-Carlson prefix adder, no carry-in, with carry-out.
module mul_seq_ctrl_hc_add
    import rv_mul_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] sum_o,
    output logic            cout_o
);
    logic [XLEN-1:0] g, p;
    // Odd bits run a Kogge-Stone tree; even bits pick up their carry in one final stage.
    // Indices descend so each in-place update still reads the previous level.
    always_comb begin
        g = a_i & b_i;
        p = a_i ^ b_i;
        for (int i = XLEN - 1; i > 0; i--)
            if (i % 2 == 1) begin
                g[i] = g[i] | (p[i] & g[i-1]);
                p[i] = p[i] & p[i-1];
            end
        for (int d = 2; d < XLEN; d = d * 2)
            for (int i = XLEN - 1; i >= d; i--)
                if (i % 2 == 1) begin
                    g[i] = g[i] | (p[i] & g[i-d]);
                    p[i] = p[i] & p[i-d];
                end
        for (int i = XLEN - 2; i > 0; i -= 2)
            g[i] = g[i] | (p[i] & g[i-1]);
        sum_o  = (a_i ^ b_i) ^ {g[XLEN-2:0], 1'b0};
        cout_o = g[XLEN-1];
    end
endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: multi-cycle radix-2 RV32M multiplier (MUL/MULH/MULHSU/MULHU) on one shared adder.
// Optional MUL_ZERO_BYPASS_EN: a zero operand completes in one cycle with product 0.
module mul_seq_ctrl
    import rv_mul_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);
    mul_state_e      state_q;
    mul_op_e         op_q;
    logic [XLEN-1:0] mcand_q, mplr_q, acc_q, add_a, add_b, sum;
    logic [CNT_W-1:0] cnt_q;
    logic            neg_b_q, neg_res_q, c_q, cout, neg_a, neg_b;
    assign neg_a = (req_op == MUL_OP_MULH || req_op == MUL_OP_MULHSU) && req_rs1[XLEN-1];
    assign neg_b = (req_op == MUL_OP_MULH) && req_rs2[XLEN-1];
    // Negations use ~x + 1; the high-word fix-up adds the carry out of the low word instead.
    always_comb begin
        add_a = state_q == S_NEG_A ? ~mcand_q :
                (state_q == S_NEG_B || state_q == S_NEG_LO) ? ~mplr_q :
                state_q == S_NEG_HI ? ~acc_q : acc_q;
        add_b = state_q == S_ITER ? (mplr_q[0] ? mcand_q : '0) :
                state_q == S_NEG_HI ? {{(XLEN-1){1'b0}}, c_q} : XLEN'(1);
    end
    mul_seq_ctrl_hc_add u_add (.a_i(add_a), .b_i(add_b), .sum_o(sum), .cout_o(cout));
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= MUL_OP_MUL;
            mcand_q   <= '0;
            mplr_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_b_q   <= 1'b0;
            neg_res_q <= 1'b0;
            c_q       <= 1'b0;
        end else if (flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    op_q      <= mul_op_e'(req_op);
                    mcand_q   <= req_rs1;
                    mplr_q    <= req_rs2;
                    acc_q     <= '0;
                    cnt_q     <= '0;
                    neg_b_q   <= neg_b;
                    neg_res_q <= neg_a ^ neg_b;
`ifdef MUL_ZERO_BYPASS_EN
                    if (req_rs1 == '0 || req_rs2 == '0) begin
                        mplr_q  <= '0;
                        state_q <= S_DONE;
                    end else
`endif
                    state_q <= neg_a ? S_NEG_A : neg_b ? S_NEG_B : S_ITER;
                end
                S_NEG_A: begin
                    mcand_q <= sum;
                    state_q <= neg_b_q ? S_NEG_B : S_ITER;
                end
                S_NEG_B: begin
                    mplr_q  <= sum;
                    state_q <= S_ITER;
                end
                S_ITER: begin
                    {acc_q, mplr_q} <= {cout & mplr_q[0], sum, mplr_q[XLEN-1:1]};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1))
                        state_q <= neg_res_q ? S_NEG_LO : S_DONE;
                end
                S_NEG_LO: begin
                    mplr_q  <= sum;
                    c_q     <= cout;
                    state_q <= S_NEG_HI;
                end
                S_NEG_HI: begin
                    acc_q   <= sum;
                    state_q <= S_DONE;
                end
                S_DONE: if (resp_ready) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
    assign req_ready  = state_q == S_IDLE;
    assign busy       = state_q != S_IDLE;
    assign resp_valid = state_q == S_DONE;
    assign resp_data  = resp_valid ? (op_q == MUL_OP_MUL ? mplr_q : acc_q) : '0;
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed and random checks of mul_seq_ctrl against a 64-bit arithmetic model.
module tb_mul_seq_ctrl;
    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, req_valid = 1'b0, resp_ready = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_rs1 = '0, req_rs2 = '0;
    logic        req_ready, resp_valid, busy;
    logic [31:0] resp_data;
    int          vectors = 0, errors = 0;

    mul_seq_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_data(resp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output int lat);
        logic        s1, s2, na, nb;
        logic [63:0] x, y, p;
        s1 = (op == 2'd1) || (op == 2'd2);
        s2 = (op == 2'd1);
        x  = s1 ? {{32{a[31]}}, a} : {32'b0, a};
        y  = s2 ? {{32{b[31]}}, b} : {32'b0, b};
        p  = x * y;
        d  = (op == 2'd0) ? p[31:0] : p[63:32];
        na = s1 & a[31];
        nb = s2 & b[31];
        lat = 33 + int'(na) + int'(nb) + 2 * int'(na ^ nb);
`ifdef MUL_ZERO_BYPASS_EN
        if (a == 0 || b == 0) lat = 1;
`endif
    endfunction

    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
        logic [31:0] exp_d;
        int          exp_lat, lat;
        model(op, a, b, exp_d, exp_lat);
        @(negedge clk);
        chk({tag, ".req_ready"}, 64'(req_ready), 64'(1));
        req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        if (exp_lat > 1) chk({tag, ".busy"}, 64'(busy), 64'(1));
        while (!resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".data"}, 64'(resp_data), 64'(exp_d));
        if (hold > 0) begin
            repeat (hold) begin @(posedge clk); #1; end
            chk({tag, ".held_data"}, 64'(resp_data), 64'(exp_d));
            chk({tag, ".held_valid"}, 64'(resp_valid), 64'(1));
            chk({tag, ".held_req_ready"}, 64'(req_ready), 64'(0));
        end
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1; resp_ready = 1'b0;
        chk({tag, ".post_valid"}, 64'(resp_valid), 64'(0));
        chk({tag, ".post_req_ready"}, 64'(req_ready), 64'(1));
    endtask

    initial begin
        logic [31:0] a, b;
        logic [1:0]  op;
        int          seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.req_ready", 64'(req_ready), 64'(1));
        chk("rst.resp_valid", 64'(resp_valid), 64'(0));
        chk("rst.resp_data", 64'(resp_data), 64'(0));
        chk("rst.busy", 64'(busy), 64'(0));
        @(negedge clk); rst = 1'b0;

        do_op("mulhu_ff", 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        do_op("mul_small", 2'd0, 32'h00012345, 32'h00000100, 0);
        do_op("mulh_7xm3", 2'd1, 32'd7, 32'hFFFFFFFD, 0);
        do_op("mulhsu_min", 2'd2, 32'h80000000, 32'h80000000, 0);
        do_op("mulh_m1xm1", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        do_op("mulh_minmin", 2'd1, 32'h80000000, 32'h80000000, 0);
        do_op("mul_zero", 2'd0, 32'h0, 32'h00001234, 0);
        do_op("mulh_negxzero", 2'd1, 32'hFFFFFFFB, 32'h0, 0);
        do_op("backpressure", 2'd1, 32'h12345678, 32'hFEDCBA98, 10);

        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd3; req_rs1 = 32'hDEADBEEF; req_rs2 = 32'h13579BDF;
        @(negedge clk); req_valid = 1'b0;
        repeat (11) @(negedge clk);
        flush = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        chk("flush.req_ready", 64'(req_ready), 64'(1));
        chk("flush.busy", 64'(busy), 64'(0));
        chk("flush.resp_valid", 64'(resp_valid), 64'(0));
        @(negedge clk); flush = 1'b0; req_valid = 1'b0;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; seen += int'(resp_valid); end
        chk("flush.no_resp", 64'(seen), 64'(0));
        do_op("after_flush", 2'd1, 32'hFFFF0001, 32'h00070003, 0);

        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd1; req_rs1 = 32'h80000001; req_rs2 = 32'h7;
        @(negedge clk); req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst.req_ready", 64'(req_ready), 64'(1));
        chk("midrst.resp_data", 64'(resp_data), 64'(0));
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; seen += int'(resp_valid); end
        chk("midrst.no_resp", 64'(seen), 64'(0));

        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: a = 32'h0;
                1: b = 32'h80000000;
                2: a = 32'hFFFFFFFF;
                default: ;
            endcase
            do_op($sformatf("rand%0d", i), op, a, b, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
